// File: rtl/fp_to_int_pipe.sv
// fp_to_int_pipe
// Three-stage pipelined float to saturated signed integer converter.
// Input value = (-1)^s * 0.M * 2^e, where e is unsigned with no bias and M
// does not have to be normalised.
//
// Optional build macro: FP_TO_INT_ROUND_NEAREST_EN
//   undefined -> truncate toward zero (the default build)
//   defined   -> round half to even on the magnitude
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous reset, active-high
//   i_valid  input word valid
//   o_ready  converter can accept an input word this cycle
//   i_fp     {sign, exponent[EXP_W], fraction[MAN_W]}
//   o_valid  result valid
//   i_ready  downstream accepts the result
//   o_int    signed saturated result
//   o_uf     nonzero fraction whose final magnitude is 0
//   o_of     result saturated
module fp_to_int_pipe #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 8,
    parameter int INT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [EXP_W+MAN_W:0]     i_fp,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [INT_W-1:0]         o_int,
    output logic                     o_uf,
    output logic                     o_of
);

    localparam int STAGES = 3;
    localparam int I_W    = MAN_W + INT_W;     // integer part after the shift
    localparam int SH_W   = 2*MAN_W + INT_W;   // shift window, fraction bits at the bottom
    localparam int R_W    = I_W + 1;           // room for the rounding carry

    // Every stage advances together; the whole pipe holds while the output stalls.
    logic en;
    logic [STAGES-1:0] vld_pipe;

    assign en      = !o_valid || i_ready;
    assign o_ready = en;
    assign o_valid = vld_pipe[STAGES-1];

    // ---------------- S1: unpack ----------------
    logic             s1_s, s1_z, s1_big;
    logic [EXP_W-1:0] s1_e;
    logic [MAN_W-1:0] s1_m;

    // ---------------- S2: shift -----------------
    logic             s2_s, s2_z, s2_big, s2_g, s2_st;
    logic [I_W-1:0]   s2_i;
    logic [SH_W-1:0]  sh;

    // ---------------- S3: round/sign/saturate ---
    logic             inc;
    logic [R_W-1:0]   mag, lim;
    logic             ovf, unf;
    logic [INT_W-1:0] res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-2:0], i_valid};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_s   <= 1'b0;
            s1_z   <= 1'b1;
            s1_big <= 1'b0;
            s1_e   <= '0;
            s1_m   <= '0;
        end else if (en) begin
            s1_s   <= i_fp[EXP_W+MAN_W];
            s1_e   <= i_fp[EXP_W+MAN_W-1:MAN_W];
            s1_m   <= i_fp[MAN_W-1:0];
            s1_z   <= (i_fp[MAN_W-1:0] == '0);
            // Beyond this exponent even M=1 lands past the integer range.
            s1_big <= (32'(i_fp[EXP_W+MAN_W-1:MAN_W]) >= 32'(MAN_W + INT_W));
        end
    end

    // M * 2^e with MAN_W fraction bits below the binary point; the integer
    // part, guard and sticky then fall out as plain bit slices.
    always_comb begin
        sh = '0;
        if (!s1_big)
            sh = SH_W'(s1_m) << s1_e;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_s   <= 1'b0;
            s2_z   <= 1'b1;
            s2_big <= 1'b0;
            s2_i   <= '0;
            s2_g   <= 1'b0;
            s2_st  <= 1'b0;
        end else if (en) begin
            s2_s   <= s1_s;
            s2_z   <= s1_z;
            s2_big <= s1_big;
            s2_i   <= sh[SH_W-1:MAN_W];
            s2_g   <= sh[MAN_W-1];
            s2_st  <= |sh[MAN_W-2:0];
        end
    end

`ifdef FP_TO_INT_ROUND_NEAREST_EN
    // Round half to even: bump on more than half, or on exactly half when odd.
    assign inc = s2_g && (s2_st || s2_i[0]);
`else
    // Truncation ignores the shifted-out bits.
    logic unused_round_bits;
    assign unused_round_bits = s2_g ^ s2_st;
    assign inc = 1'b0;
`endif

    always_comb begin
        mag = R_W'(s2_i) + R_W'(inc);
        // Negative side reaches one further: -2^(INT_W-1) is representable.
        lim = R_W'(1) << (INT_W-1);
        if (!s2_s)
            lim = lim - R_W'(1);
        // A zero fraction is exactly zero regardless of exponent or sign.
        ovf = !s2_z && (s2_big || (mag > lim));
        unf = !s2_z && !ovf && (mag == '0);
        if (ovf)
            res = s2_s ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
        else if (s2_s)
            res = -mag[INT_W-1:0];
        else
            res = mag[INT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_int <= '0;
            o_uf  <= 1'b0;
            o_of  <= 1'b0;
        end else if (en) begin
            o_int <= res;
            o_uf  <= unf;
            o_of  <= ovf;
        end
    end

endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Bench for fp_to_int_pipe at default parameters (EXP_W=4, MAN_W=8, INT_W=8).
// Directed vector table, reset-in-flight, back-to-back latency/throughput and
// randomized backpressure traffic checked against an arithmetic reference.
module tb_fp_to_int_pipe;

    typedef struct packed {
        logic [7:0] v;
        logic       uf;
        logic       of;
    } exp_t;

    typedef struct {
        logic [12:0] fp;
        exp_t        e;
    } vec_t;

`ifdef FP_TO_INT_ROUND_NEAREST_EN
    localparam bit RN = 1'b1;
`else
    localparam bit RN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [12:0] i_fp = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [7:0]  o_int;
    logic        o_uf;
    logic        o_of;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    exp_t sb[$];
    int   out_cyc[$];
    vec_t vecs[$];

    fp_to_int_pipe #(.EXP_W(4), .MAN_W(8), .INT_W(8)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_fp(i_fp),
        .o_valid(o_valid), .i_ready(i_ready), .o_int(o_int), .o_uf(o_uf), .o_of(o_of)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: value = M / 2^8 * 2^e, computed with integer division.
    function automatic exp_t model(input logic [12:0] fp);
        exp_t   r;
        logic   s;
        int     e, m;
        longint mag, den, rem, half, lim;
        s = fp[12];
        e = int'(fp[11:8]);
        m = int'(fp[7:0]);
        r = '0;
        if (e >= 8) begin
            mag = longint'(m) << (e - 8);
            rem = 0;
            half = 1;
        end else begin
            den  = longint'(1) << (8 - e);
            mag  = m / den;
            rem  = m % den;
            half = den / 2;
        end
        if (RN && (rem > half || (rem == half && (mag % 2) == 1)))
            mag = mag + 1;
        lim = s ? 128 : 127;
        if (m == 0) begin
            r = '0;
        end else if (mag > lim) begin
            r.of = 1'b1;
            r.v  = s ? 8'h80 : 8'h7F;
        end else begin
            r.v  = s ? 8'(-mag) : 8'(mag);
            r.uf = (mag == 0);
        end
        return r;
    endfunction

    function automatic void add_vec(input logic [12:0] fp, input logic [7:0] t_v, input logic t_uf,
                                    input logic [7:0] r_v, input logic r_uf, input logic of);
        vec_t x;
        x.fp   = fp;
        x.e.v  = RN ? r_v : t_v;
        x.e.uf = RN ? r_uf : t_uf;
        x.e.of = of;
        vecs.push_back(x);
    endfunction

    // Output monitor: scoreboard compare on every transfer out, and stall
    // stability whenever the previous cycle was held.
    logic       stall_prev = 1'b0;
    logic [9:0] snap;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                tests++;
                if (!o_valid || {o_int, o_uf, o_of} !== snap) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%b %h/%b/%b, required held %h/%b/%b",
                             o_valid, o_int, o_uf, o_of, snap[9:2], snap[1], snap[0]);
                end
            end
            if (o_valid && !i_ready) begin
                tests++;
                if (o_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_ready: o_ready=%b, required 0", o_ready);
                end
                snap = {o_int, o_uf, o_of};
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (o_valid && i_ready) begin
                exp_t x;
                out_cyc.push_back(cyc);
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out: got %h uf=%b of=%b, required no output", o_int, o_uf, o_of);
                end else begin
                    x = sb.pop_front();
                    if (o_int !== x.v || o_uf !== x.uf || o_of !== x.of) begin
                        fails++;
                        $display("FAIL result: got %h uf=%b of=%b, required %h uf=%b of=%b",
                                 o_int, o_uf, o_of, x.v, x.uf, x.of);
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word was accepted.
    task automatic push_word(input logic [12:0] fp, input exp_t e, input int pct, output int acc_cyc);
        bit acc = 0;
        acc_cyc = -1;
        i_fp    = fp;
        i_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            i_ready = ($urandom_range(0, 99) < pct);
            @(negedge clk);
            if (o_ready) begin
                sb.push_back(e);
                acc_cyc = cyc;
                acc = 1;
            end
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: word %h not accepted, required acceptance", fp);
        end
    endtask

    task automatic idle(input int n, input int pct);
        i_valid = 1'b0;
        repeat (n) begin
            i_ready = ($urandom_range(0, 99) < pct);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        int   ac, first;
        logic [12:0] fp;

        //          fp        trunc       round-nearest  of
        add_vec(13'h0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        add_vec(13'h1000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        add_vec(13'h00FF, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        add_vec(13'h10FF, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
        add_vec(13'h0180, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0);
        add_vec(13'h1180, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0);
        add_vec(13'h01F0, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        add_vec(13'h11F0, 8'hFF, 1'b0, 8'hFE, 1'b0, 1'b0);
        add_vec(13'h02A0, 8'h02, 1'b0, 8'h02, 1'b0, 1'b0);
        add_vec(13'h0880, 8'h7F, 1'b0, 8'h7F, 1'b0, 1'b1);
        add_vec(13'h1880, 8'h80, 1'b0, 8'h80, 1'b0, 1'b0);
        add_vec(13'h0FFF, 8'h7F, 1'b0, 8'h7F, 1'b0, 1'b1);
        add_vec(13'h1FFF, 8'h80, 1'b0, 8'h80, 1'b0, 1'b1);
        add_vec(13'h04FF, 8'h0F, 1'b0, 8'h10, 1'b0, 1'b0);
        add_vec(13'h0780, 8'h40, 1'b0, 8'h40, 1'b0, 1'b0);
        add_vec(13'h0001, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        add_vec(13'h1F00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (o_valid !== 1'b0 || o_int !== 8'h00 || o_uf !== 1'b0 || o_of !== 1'b0 || o_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: got v=%b int=%h uf=%b of=%b rdy=%b, required 0/00/0/0/1",
                     o_valid, o_int, o_uf, o_of, o_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vector table
        foreach (vecs[i]) push_word(vecs[i].fp, vecs[i].e, 100, ac);
        drain();

        // Reset with three words in flight: stacked up behind a stalled output
        for (int i = 0; i < 3; i++) push_word(13'h0180 + 13'(i), model(13'h0180 + 13'(i)), 0, ac);
        i_valid = 1'b0;
        #2;
        tests++;
        if (o_valid !== 1'b1) begin
            fails++;
            $display("FAIL inflight_fill: o_valid=%b, required 1 before reset", o_valid);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (o_valid !== 1'b0 || o_int !== 8'h00) begin
            fails++;
            $display("FAIL async_reset: got v=%b int=%h, required 0/00", o_valid, o_int);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        idle(10, 100);   // any reappearing word shows up as unexpected_out

        // Back-to-back: 16 words, first result 3 cycles after accept, 1/cycle
        out_cyc.delete();
        first = -1;
        for (int i = 0; i < 16; i++) begin
            fp = 13'($urandom);
            push_word(fp, model(fp), 100, ac);
            if (i == 0) first = ac;
        end
        drain();
        tests++;
        if (out_cyc.size() != 16) begin
            fails++;
            $display("FAIL b2b_count: got %0d results, required 16", out_cyc.size());
        end else begin
            tests++;
            if (out_cyc[0] - first != 3) begin
                fails++;
                $display("FAIL b2b_latency: got %0d cycles, required 3", out_cyc[0] - first);
            end
            tests++;
            if (out_cyc[15] - out_cyc[0] != 15) begin
                fails++;
                $display("FAIL b2b_throughput: got %0d cycles for 16 results, required 15", out_cyc[15] - out_cyc[0]);
            end
        end

        // Random traffic with 30% downstream ready
        for (int w = 0; w < 200; w++) begin
            fp = 13'($urandom);
            push_word(fp, model(fp), 30, ac);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), 30);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
